fetch_unit: RTL and testbench

Instruction-fetch (F) stage of the 5-stage MIPS pipeline. It owns the fetch PC, issues single-outstanding requests to instruction memory, and presents {pc_f, instr_f, valid_f, exc_adel_f} to the F/D pipeline register. It honours the hazard unit's stall and the D/E-stage branch/jump redirect. It produces a nop bubble (instr 0) whenever no instruction is ready.

---
 rtl/fetch_if.sv | 25 ++
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction-memory handshake and F/D outputs.
// The master modport is the fetch unit; the slave modport is the pipeline/memory side.
interface fetch_if;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic [31:0] pc_f;
  logic [31:0] instr_f;
  logic        valid_f;
  logic        exc_adel_f;

  modport master (
    input  stall, redirect_en, redirect_pc, im_rvalid, im_rdata,
    output im_req, im_addr, pc_f, instr_f, valid_f, exc_adel_f
  );

  modport slave (
    output stall, redirect_en, redirect_pc, im_rvalid, im_rdata,
    input  im_req, im_addr, pc_f, instr_f, valid_f, exc_adel_f
  );
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: owns the fetch PC, keeps one memory request in flight and
// presents each fetched word (or an address-error bubble) to the F/D register for one cycle.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT = 32'h0000_6FFC
) (
  input logic     clk,
  input logic     reset,
  fetch_if.master bus
);

  typedef enum logic [1:0] {StReq, StWait, StHold, StDrain} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_buf_q;
  logic        adel_q;
  logic        pc_legal;

  assign pc_legal = (pc_q[1:0] == 2'b00) && (pc_q >= IM_BASE) && (pc_q <= IM_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StReq;
      pc_q        <= RESET_PC;
      instr_buf_q <= 32'h0;
      adel_q      <= 1'b0;
    end else if (bus.redirect_en) begin
      pc_q   <= bus.redirect_pc;
      adel_q <= 1'b0;
      unique case (state_q)
        // An illegal PC issues nothing in REQ, so there is no response to drain.
        StReq:   state_q <= pc_legal ? StDrain : StReq;
        StWait:  state_q <= bus.im_rvalid ? StReq : StDrain;
        StHold:  state_q <= StReq;
        StDrain: state_q <= bus.im_rvalid ? StReq : StDrain;
        default: state_q <= StReq;
      endcase
    end else begin
      unique case (state_q)
        StReq: begin
          if (pc_legal) begin
            state_q <= StWait;
          end else begin
            instr_buf_q <= 32'h0;
            adel_q      <= 1'b1;
            state_q     <= StHold;
          end
        end
        StWait: begin
          if (bus.im_rvalid) begin
            instr_buf_q <= bus.im_rdata;
            adel_q      <= 1'b0;
            state_q     <= StHold;
          end
        end
        StHold: begin
          if (!bus.stall) begin
            pc_q    <= pc_q + 32'd4;
            state_q <= StReq;
          end
        end
        StDrain: begin
          if (bus.im_rvalid) begin
            state_q <= StReq;
          end
        end
        default: state_q <= StReq;
      endcase
    end
  end

  always_comb begin
    bus.im_req     = (state_q == StReq) && pc_legal;
    bus.im_addr    = pc_q;
    bus.pc_f       = pc_q;
    bus.valid_f    = (state_q == StHold);
    bus.instr_f    = bus.valid_f ? instr_buf_q : 32'h0;
    bus.exc_adel_f = bus.valid_f & adel_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: scripted cycle table, directed multi-cycle sequences, and a random
// run checked against a PC-stream/memory-content model.
module tb_fetch_unit;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;

  logic clk;
  logic reset;
  fetch_if bus ();

  fetch_unit dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        rvalid;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } vec_t;

  vec_t        vec [32];
  int          errors = 0;
  int          checks = 0;
  logic        pend;
  int          cnt;
  logic [31:0] paddr;
  logic [31:0] exp_pc;

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                              input logic v, input logic [31:0] rd, input logic req,
                              input logic [31:0] addr, input logic val, input logic [31:0] pc,
                              input logic [31:0] instr, input logic adel);
    mk = '{s, r, rpc, v, rd, req, addr, val, pc, instr, adel};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    mem_word = {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic legal(input logic [31:0] a);
    legal = (a % 4 == 0) && (a >= 32'h3000) && (a <= 32'h6FFC);
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.im_rvalid = 1'b0;
    bus.im_rdata = 32'h0;
    pend = 1'b0;
    cnt = 0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  // Memory answers each request exactly lat cycles after the cycle im_req is high.
  task automatic mem_service(input int lat);
    bus.im_rvalid = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        bus.im_rvalid = 1'b1;
        bus.im_rdata = mem_word(paddr);
        pend = 1'b0;
      end
    end
    if (bus.im_req) begin
      pend = 1'b1;
      cnt = lat;
      paddr = bus.im_addr;
    end
  endtask

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 7))
      0:       rand_target = 32'h3000 + 32'($urandom_range(0, 16'h3FFF)) | 32'h1;
      1:       rand_target = 32'h7000 + 32'($urandom_range(0, 255)) * 4;
      2:       rand_target = 32'h2000 + 32'($urandom_range(0, 1023)) * 4;
      default: rand_target = 32'h3000 + 32'($urandom_range(0, 12'hFFF)) * 4;
    endcase
  endfunction

  initial begin
    logic        found;
    logic        zero_ok;
    int          npulse;
    int          idle;
    logic [96:0] snap;
    logic [31:0] addr_seen;
    logic        ill;
    logic        rst;
    logic        st;
    logic        rd;
    logic [31:0] tgt;

    //        s  r  rpc           v  rdata          req addr          v  pc            instr          a
    vec[0]  = mk(0, 0, 32'h0,      0, 32'h0,        1, 32'h3000,      0, 32'h3000,     32'h0,        0);
    vec[1]  = mk(0, 0, 32'h0,      1, 32'h24010005, 0, 32'h0,         0, 32'h3000,     32'h0,        0);
    vec[2]  = mk(0, 0, 32'h0,      0, 32'h0,        0, 32'h0,         1, 32'h3000,     32'h24010005, 0);
    vec[3]  = mk(0, 0, 32'h0,      0, 32'h0,        1, 32'h3004,      0, 32'h3004,     32'h0,        0);
    vec[4]  = mk(0, 1, 32'h3400,   0, 32'h0,        0, 32'h0,         0, 32'h3004,     32'h0,        0);
    vec[5]  = mk(0, 0, 32'h0,      0, 32'h0,        0, 32'h0,         0, 32'h3400,     32'h0,        0);
    vec[6]  = mk(0, 0, 32'h0,      1, DB,           0, 32'h0,         0, 32'h3400,     32'h0,        0);
    vec[7]  = mk(0, 0, 32'h0,      0, 32'h0,        1, 32'h3400,      0, 32'h3400,     32'h0,        0);
    vec[8]  = mk(0, 0, 32'h0,      1, 32'h11112222, 0, 32'h0,         0, 32'h3400,     32'h0,        0);
    vec[9]  = mk(1, 1, 32'h3002,   0, 32'h0,        0, 32'h0,         1, 32'h3400,     32'h11112222, 0);
    vec[10] = mk(0, 0, 32'h0,      0, 32'h0,        0, 32'h0,         0, 32'h3002,     32'h0,        0);
    vec[11] = mk(0, 1, 32'h7000,   0, 32'h0,        0, 32'h0,         1, 32'h3002,     32'h0,        1);
    vec[12] = mk(0, 0, 32'h0,      1, DB,           0, 32'h0,         0, 32'h7000,     32'h0,        0);
    vec[13] = mk(0, 1, 32'h3008,   1, DB,           0, 32'h0,         1, 32'h7000,     32'h0,        1);
    vec[14] = mk(0, 0, 32'h0,      0, 32'h0,        1, 32'h3008,      0, 32'h3008,     32'h0,        0);
    vec[15] = mk(0, 1, 32'h3100,   1, DB,           0, 32'h0,         0, 32'h3008,     32'h0,        0);
    vec[16] = mk(0, 1, 32'h3200,   0, 32'h0,        1, 32'h3100,      0, 32'h3100,     32'h0,        0);
    vec[17] = mk(0, 1, 32'h3300,   0, 32'h0,        0, 32'h0,         0, 32'h3200,     32'h0,        0);
    vec[18] = mk(0, 0, 32'h0,      1, DB,           0, 32'h0,         0, 32'h3300,     32'h0,        0);
    vec[19] = mk(0, 0, 32'h0,      0, 32'h0,        1, 32'h3300,      0, 32'h3300,     32'h0,        0);
    vec[20] = mk(0, 0, 32'h0,      1, 32'hCAFE0001, 0, 32'h0,         0, 32'h3300,     32'h0,        0);
    vec[21] = mk(0, 0, 32'h0,      0, 32'h0,        0, 32'h0,         1, 32'h3300,     32'hCAFE0001, 0);
    vec[22] = mk(0, 1, 32'h6FFC,   0, 32'h0,        1, 32'h3304,      0, 32'h3304,     32'h0,        0);
    vec[23] = mk(0, 0, 32'h0,      1, DB,           0, 32'h0,         0, 32'h6FFC,     32'h0,        0);
    vec[24] = mk(0, 0, 32'h0,      0, 32'h0,        1, 32'h6FFC,      0, 32'h6FFC,     32'h0,        0);
    vec[25] = mk(0, 0, 32'h0,      1, 32'h0000000C, 0, 32'h0,         0, 32'h6FFC,     32'h0,        0);
    vec[26] = mk(0, 0, 32'h0,      0, 32'h0,        0, 32'h0,         1, 32'h6FFC,     32'h0000000C, 0);
    vec[27] = mk(0, 0, 32'h0,      0, 32'h0,        0, 32'h0,         0, 32'h7000,     32'h0,        0);
    vec[28] = mk(0, 1, 32'h2FFC,   0, 32'h0,        0, 32'h0,         1, 32'h7000,     32'h0,        1);
    vec[29] = mk(0, 0, 32'h0,      0, 32'h0,        0, 32'h0,         0, 32'h2FFC,     32'h0,        0);
    vec[30] = mk(0, 1, 32'h3000,   0, 32'h0,        0, 32'h0,         1, 32'h2FFC,     32'h0,        1);
    vec[31] = mk(0, 0, 32'h0,      0, 32'h0,        1, 32'h3000,      0, 32'h3000,     32'h0,        0);

    // Scripted cycle table; im_addr is only compared when a request is expected.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      addr_seen = vec[i].req ? bus.im_addr : 32'h0;
      chk($sformatf("vec%0d", i),
          128'({bus.im_req, addr_seen, bus.valid_f, bus.pc_f, bus.instr_f, bus.exc_adel_f}),
          128'({vec[i].req, vec[i].addr, vec[i].valid, vec[i].pc, vec[i].instr, vec[i].adel}));
      bus.stall = vec[i].stall;
      bus.redirect_en = vec[i].redir;
      bus.redirect_pc = vec[i].rpc;
      bus.im_rvalid = vec[i].rvalid;
      bus.im_rdata = vec[i].rdata;
      next_cycle();
    end

    // Sequential fetch, latency 3: pulses every 5 cycles starting at cycle 4.
    do_reset();
    npulse = 0;
    zero_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (bus.valid_f) begin
        if (npulse < 4) begin
          chk("seq_pulse", 128'({32'(c), bus.pc_f, bus.instr_f}),
              128'({32'(4 + 5 * npulse), 32'h3000 + 32'(4 * npulse),
                    mem_word(32'h3000 + 32'(4 * npulse))}));
        end
        npulse++;
      end else if (bus.instr_f != 32'h0) begin
        zero_ok = 1'b0;
      end
      mem_service(3);
      next_cycle();
    end
    chk("seq_count", 128'(npulse), 128'(4));
    chk("seq_gap_zero", 128'(zero_ok), 128'(1));

    // Stall held for four cycles in HOLD, then release.
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bus.valid_f) found = 1'b1;
      else begin
        mem_service(1);
        next_cycle();
      end
    end
    chk("stall_reach", 128'(found), 128'(1));
    snap = {bus.pc_f, bus.instr_f, bus.valid_f, bus.pc_f};
    bus.im_rvalid = 1'b0;
    bus.stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) bus.stall = 1'b0;
      chk("stall_hold", 128'({bus.pc_f, bus.instr_f, bus.valid_f, bus.pc_f, bus.im_req}),
          128'({snap, 1'b0}));
      next_cycle();
    end
    chk("stall_next", 128'({bus.im_req, bus.im_addr, bus.valid_f}),
        128'({1'b1, snap[96:65] + 32'd4, 1'b0}));

    // Reset asserted while a request is outstanding.
    do_reset();
    mem_service(2);
    next_cycle();
    reset = 1'b1;
    bus.im_rvalid = 1'b0;
    pend = 1'b0;
    next_cycle();
    reset = 1'b0;
    chk("reset_wait", 128'({bus.im_req, bus.im_addr, bus.valid_f, bus.pc_f}),
        128'({1'b1, 32'h3000, 1'b0, 32'h3000}));

    // Random run: PC stream model plus memory content and address legality.
    do_reset();
    exp_pc = 32'h3000;
    idle = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_pc", 128'(bus.pc_f), 128'(exp_pc));
      if (bus.im_req) chk("rnd_req", 128'({pend, bus.im_addr}), 128'({1'b0, exp_pc}));
      if (bus.valid_f) begin
        ill = !legal(exp_pc);
        chk("rnd_out", 128'({bus.instr_f, bus.exc_adel_f}),
            128'({ill ? 32'h0 : mem_word(exp_pc), ill}));
        idle = 0;
      end else begin
        chk("rnd_bubble", 128'({bus.instr_f, bus.exc_adel_f}), 128'(0));
        idle++;
      end
      if (idle > 300) begin
        chk("rnd_live", 128'(idle), 128'(300));
        idle = 0;
      end
      mem_service($urandom_range(1, 4));
      rst = ($urandom_range(0, 199) == 0);
      st = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 31) == 0);
      tgt = rand_target();
      reset = rst;
      bus.stall = st;
      bus.redirect_en = rd;
      bus.redirect_pc = tgt;
      if (rst) begin
        bus.im_rvalid = 1'b0;
        pend = 1'b0;
        exp_pc = 32'h3000;
      end else if (rd) begin
        exp_pc = tgt;
      end else if (bus.valid_f && !st) begin
        exp_pc = exp_pc + 32'd4;
      end
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
